// File: rtl/uart_pkg.sv
// Shared constants and types for the UART baud generator.
// Widths, reset divisor and the run/restart mode shared by the baud generator files.
package uart_pkg;

  localparam int DFLT_INT_W      = 16;
  localparam int DFLT_FRAC_W     = 4;
  localparam int DFLT_OVERSAMPLE = 16;
  localparam int RST_INT         = 325;
  localparam int RST_FRAC        = 8;
  localparam int PH_W            = $clog2(DFLT_OVERSAMPLE);

  typedef enum logic {
    MODE_RESTART = 1'b0,
    MODE_COUNT   = 1'b1
  } mode_e;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds the fractional divisor once per oversample period.
// The carry out stretches the following period by one clock.
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = DFLT_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   sum;

  assign sum     = {1'b0, acc_q} + {1'b0, frac_i};
  assign carry_o = sum[FRAC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (step_i) begin
      acc_q <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_gen_prog.sv
// Programmable fractional baud generator: oversample, mid-bit and bit-end ticks.
// New divisors wait in a shadow register and are committed only at a bit boundary.
module baud_gen_prog
  import uart_pkg::*;
#(
  parameter int INT_W      = DFLT_INT_W,
  parameter int FRAC_W     = DFLT_FRAC_W,
  parameter int OVERSAMPLE = DFLT_OVERSAMPLE,
  parameter int DEF_INT    = RST_INT,
  parameter int DEF_FRAC   = RST_FRAC,
  localparam int PHASE_W   = $clog2(OVERSAMPLE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               resync,
  input  logic               cfg_wr,
  input  logic [INT_W-1:0]   cfg_int,
  input  logic [FRAC_W-1:0]  cfg_frac,
  output logic               cfg_busy,
  output logic               cfg_err,
  output logic               os_tick,
  output logic               mid_tick,
  output logic               baud_tick,
  output logic [PHASE_W-1:0] os_phase
);

  typedef struct packed {
    logic [INT_W-1:0]  int_v;
    logic [FRAC_W-1:0] frac_v;
  } cfg_t;

  localparam logic [INT_W-1:0]   MIN_INT   = INT_W'(2);
  localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PH_PREMID = PHASE_W'(OVERSAMPLE / 2 - 1);
  localparam cfg_t               RST_CFG   = '{int_v: INT_W'(DEF_INT), frac_v: FRAC_W'(DEF_FRAC)};

  logic [INT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  cfg_t               act_q, act_d;
  cfg_t               shd_q, shd_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               os_tick_q, os_tick_d;
  logic               mid_tick_q, mid_tick_d;
  logic               baud_tick_q, baud_tick_d;

  mode_e              mode;
  logic               wrap;
  logic               bit_end;
  logic               commit;
  logic               carry;
  logic [INT_W-1:0]   nxt_int;
  cfg_t               wr_cfg;

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear_i (mode == MODE_RESTART),
    .step_i  (wrap),
    .frac_i  (act_q.frac_v),
    .carry_o (carry)
  );

  always_comb begin
    mode    = (!enable || resync) ? MODE_RESTART : MODE_COUNT;
    wrap    = (mode == MODE_COUNT) && (cnt_q == '0);
    bit_end = wrap && (phase_q == PH_LAST);
    // Committing on the reload edge lets the new divisor govern the very next period.
    commit  = busy_q && ((mode == MODE_RESTART) || bit_end);
    nxt_int = commit ? shd_q.int_v : act_q.int_v;

    wr_cfg.int_v  = (cfg_int < MIN_INT) ? MIN_INT : cfg_int;
    wr_cfg.frac_v = cfg_frac;

    act_d  = commit ? shd_q : act_q;
    shd_d  = cfg_wr ? wr_cfg : shd_q;
    busy_d = cfg_wr ? 1'b1 : (commit ? 1'b0 : busy_q);
    err_d  = cfg_wr && (cfg_int < MIN_INT);

    cnt_d       = cnt_q;
    phase_d     = phase_q;
    os_tick_d   = 1'b0;
    mid_tick_d  = 1'b0;
    baud_tick_d = 1'b0;

    if (mode == MODE_RESTART) begin
      cnt_d   = nxt_int - INT_W'(1);
      phase_d = '0;
    end else if (wrap) begin
      cnt_d       = nxt_int - INT_W'(1) + INT_W'(carry);
      phase_d     = phase_q + PHASE_W'(1);
      os_tick_d   = 1'b1;
      mid_tick_d  = (phase_q == PH_PREMID);
      baud_tick_d = (phase_q == PH_LAST);
    end else begin
      cnt_d = cnt_q - INT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= INT_W'(DEF_INT - 1);
      phase_q     <= '0;
      act_q       <= RST_CFG;
      shd_q       <= RST_CFG;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      os_tick_q   <= 1'b0;
      mid_tick_q  <= 1'b0;
      baud_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      os_tick_q   <= os_tick_d;
      mid_tick_q  <= mid_tick_d;
      baud_tick_q <= baud_tick_d;
    end
  end

  assign cfg_busy  = busy_q;
  assign cfg_err   = err_q;
  assign os_tick   = os_tick_q;
  assign mid_tick  = mid_tick_q;
  assign baud_tick = baud_tick_q;
  assign os_phase  = phase_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Bench for baud_gen_prog: tick intervals are pushed as expectations and checked as ticks arrive.
module tb_baud_gen_prog;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        reset, enable, resync, cfg_wr;
  logic [15:0] cfg_int;
  logic [3:0]  cfg_frac;
  logic        cfg_busy, cfg_err, os_tick, mid_tick, baud_tick;
  logic [3:0]  os_phase;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [31:0] os_exp_q[$];
  logic [31:0] baud_exp_q[$];
  logic [31:0] mid_exp_q[$];
  int unsigned os_last, baud_last;
  bit          os_have = 1'b0;
  bit          baud_have = 1'b0;

  baud_gen_prog dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .resync    (resync),
    .cfg_wr    (cfg_wr),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err),
    .os_tick   (os_tick),
    .mid_tick  (mid_tick),
    .baud_tick (baud_tick),
    .os_phase  (os_phase)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: compare tick intervals against the expected queues
  always @(negedge clk) begin
    if (!reset) begin
      if (mid_tick) begin
        check_val("mid_phase", 32'(os_phase), OS / 2);
        if (baud_have && mid_exp_q.size() > 0)
          check_val("mid_offset", cyc - baud_last, mid_exp_q.pop_front());
      end
      if (baud_tick) begin
        check_val("baud_phase", 32'(os_phase), 0);
        if (baud_have && baud_exp_q.size() > 0)
          check_val("baud_period", cyc - baud_last, baud_exp_q.pop_front());
        baud_last = cyc;
        baud_have = 1'b1;
      end
      if (os_tick) begin
        if (os_have && os_exp_q.size() > 0)
          check_val("os_period", cyc - os_last, os_exp_q.pop_front());
        os_last = cyc;
        os_have = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int iv, input int fv);
    cfg_int  = 16'(iv);
    cfg_frac = 4'(fv);
    cfg_wr   = 1'b1;
    step();
    cfg_wr   = 1'b0;
  endtask

  task automatic restart_refs();
    os_have   = 1'b0;
    baud_have = 1'b0;
  endtask

  task automatic push_os(input int v, input int n);
    for (int i = 0; i < n; i++) os_exp_q.push_back(32'(v));
  endtask

  task automatic push_frac_model(input int iv, input int fv, input int n);
    int acc = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc + fv;
      os_exp_q.push_back(32'(iv + ((acc >= 16) ? 1 : 0)));
      acc = acc % 16;
    end
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n = 0;
    while ((os_exp_q.size() + baud_exp_q.size() + mid_exp_q.size()) > 0 && n < bound) begin
      step();
      n++;
    end
    check_val(tag, 32'(os_exp_q.size() + baud_exp_q.size() + mid_exp_q.size()), 0);
    os_exp_q.delete();
    baud_exp_q.delete();
    mid_exp_q.delete();
  endtask

  task automatic wait_phase(input int ph, input int bound);
    int n = 0;
    while (32'(os_phase) != 32'(ph) && n < bound) begin
      step();
      n++;
    end
    check_val("wait_phase", 32'(os_phase), 32'(ph));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_os"}, 32'(os_tick), 0);
    check_val({tag, "_mid"}, 32'(mid_tick), 0);
    check_val({tag, "_baud"}, 32'(baud_tick), 0);
    check_val({tag, "_phase"}, 32'(os_phase), 0);
    check_val({tag, "_busy"}, 32'(cfg_busy), 0);
    check_val({tag, "_err"}, 32'(cfg_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; resync = 1'b0; cfg_wr = 1'b0;
    cfg_int = '0; cfg_frac = '0;
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    // integer divisor 4, programmed while stopped
    write_cfg(4, 0);
    check_val("wr_busy", 32'(cfg_busy), 1);
    check_val("wr_noerr", 32'(cfg_err), 0);
    step();
    check_val("restart_commit", 32'(cfg_busy), 0);
    restart_refs();
    push_os(4, 20);
    baud_exp_q.push_back(64); baud_exp_q.push_back(64);
    mid_exp_q.push_back(32);  mid_exp_q.push_back(32);
    enable = 1'b1;
    wait_drain(1000, "drain_int4");

    // divisor 4.5: periods alternate 4/5, 72 clocks per bit
    enable = 1'b0;
    step();
    write_cfg(4, 8);
    step();
    check_val("frac_commit", 32'(cfg_busy), 0);
    restart_refs();
    push_frac_model(4, 8, 32);
    baud_exp_q.push_back(72); baud_exp_q.push_back(72);
    enable = 1'b1;
    wait_drain(1000, "drain_frac");

    // reprogram mid-bit: old period holds until the bit ends
    enable = 1'b0;
    step();
    write_cfg(4, 0);
    step();
    restart_refs();
    enable = 1'b1;
    wait_phase(3, 200);
    @(negedge clk);
    #1;
    push_os(4, 13);
    push_os(8, 4);
    cfg_int = 16'd8; cfg_frac = 4'd0; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    check_val("midbit_busy", 32'(cfg_busy), 1);
    for (int n = 0; n < 200 && !baud_tick; n++) step();
    check_val("midbit_baud_seen", 32'(baud_tick), 1);
    check_val("midbit_commit", 32'(cfg_busy), 0);
    wait_drain(300, "drain_midbit");

    // divisor below 2 is clamped and flagged
    enable = 1'b0;
    step();
    write_cfg(1, 0);
    check_val("err_pulse", 32'(cfg_err), 1);
    check_val("err_busy", 32'(cfg_busy), 1);
    step();
    check_val("err_clear", 32'(cfg_err), 0);
    check_val("err_commit", 32'(cfg_busy), 0);
    restart_refs();
    push_os(2, 8);
    enable = 1'b1;
    wait_drain(200, "drain_clamp");

    // resync at phase 9
    enable = 1'b0;
    step();
    write_cfg(4, 0);
    step();
    restart_refs();
    enable = 1'b1;
    wait_phase(9, 300);
    @(negedge clk);
    #1;
    resync = 1'b1;
    step();
    resync = 1'b0;
    check_val("resync_phase", 32'(os_phase), 0);
    check_val("resync_notick", 32'(os_tick), 0);
    os_last   = cyc;
    os_have   = 1'b1;
    baud_have = 1'b0;
    push_os(4, 4);
    wait_drain(200, "drain_resync");

    // async reset mid-bit with a pending write
    wait_phase(5, 200);
    write_cfg(6, 0);
    check_val("pre_reset_busy", 32'(cfg_busy), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    step();
    reset = 1'b0;
    restart_refs();
    push_frac_model(325, 8, 3);
    wait_drain(2000, "drain_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
